offnariscv_wb: RTL

//  Writeback/commit stage; directly downstream of EX. Joins the EX sideband beat (exwb_tdata_t) with the matching unit result (aluwb/bruwb/syswb).

---
 rtl/offnariscv_pkg.sv | 84 ++++++++
 rtl/offnariscv_wb_join.sv | 63 ++++++
 rtl/offnariscv_wb.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/offnariscv_pkg.sv
// offnariscv_pkg: shared widths, stream beat types and writeback-stage types.
package offnariscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        EXC_INSN_MISALIGNED = 5'd0,
        EXC_INSN_FAULT      = 5'd1,
        EXC_ILLEGAL_INSN    = 5'd2,
        EXC_BREAKPOINT      = 5'd3,
        EXC_ECALL_M         = 5'd11
    } exc_code_e;

    typedef enum logic [4:0] {
        INT_SW_M    = 5'd3,
        INT_TIMER_M = 5'd7,
        INT_EXT_M   = 5'd11
    } int_code_e;

    typedef union packed {
        exc_code_e exc;
        int_code_e irq;
    } int_exc_code_u;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            int_exc_valid;
        int_exc_code_u   int_exc_code;
    } if_data_t;

    typedef struct packed {
        logic        alu_cmd_vld;
        logic        bru_cmd_vld;
        logic        sys_cmd_vld;
        logic        mret;
        logic        sret;
        logic [4:0]  rd;
        logic [11:0] csr_addr;
    } id_data_t;

    typedef struct packed {
        logic [XLEN-1:0] mtvec;
        logic [XLEN-1:0] mepc;
        logic [XLEN-1:0] csr_rdata;
    } rf_data_t;

    typedef struct packed {
        if_data_t if_data;
        id_data_t id_data;
        rf_data_t rf_data;
    } exwb_tdata_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
    } aluwb_tdata_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] new_pc;
        logic            taken;
        logic            jump;
    } bruwb_tdata_t;

    typedef struct packed {
        logic [XLEN-1:0] csr_wdata;
        logic            csr_update;
    } syswb_tdata_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } wbrf_tdata_t;

    typedef enum logic [0:0] {
        WB_RUN  = 1'b0,
        WB_KILL = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } redirect_t;

endpackage

// File: rtl/offnariscv_wb_join.sv
// offnariscv_wb_join: combinational unit select, stream join and commit/redirect/CSR decode.
module offnariscv_wb_join
    import offnariscv_pkg::*;
(
    input  logic            can_accept_i,
    input  logic            exwb_valid_i,
    input  exwb_tdata_t     exwb_i,
    input  logic            alu_valid_i,
    input  aluwb_tdata_t    alu_i,
    input  logic            bru_valid_i,
    input  bruwb_tdata_t    bru_i,
    input  logic            sys_valid_i,
    input  syswb_tdata_t    sys_i,
    output logic            exwb_ready_o,
    output logic            alu_ready_o,
    output logic            bru_ready_o,
    output logic            sys_ready_o,
    output logic            accept_o,
    output wbrf_tdata_t     wbrf_o,
    output redirect_t       redirect_o,
    output logic            trap_o,
    output int_exc_code_u   cause_o,
    output logic            csr_we_o,
    output logic [XLEN-1:0] csr_wdata_o
);

    logic exc, alu, bru, sys, mret, unit_vld, writes;

    // An exception beat carries no unit result, so it never selects a unit.
    assign exc      = exwb_i.if_data.int_exc_valid;
    assign alu      = !exc && exwb_i.id_data.alu_cmd_vld;
    assign bru      = !exc && exwb_i.id_data.bru_cmd_vld;
    assign sys      = !exc && exwb_i.id_data.sys_cmd_vld;
    assign mret     = sys && exwb_i.id_data.mret;
    assign unit_vld = alu ? alu_valid_i : bru ? bru_valid_i : sys ? sys_valid_i : 1'b1;

    assign accept_o     = can_accept_i && exwb_valid_i && unit_vld;
    assign exwb_ready_o = accept_o;
    assign alu_ready_o  = accept_o && alu;
    assign bru_ready_o  = accept_o && bru;
    assign sys_ready_o  = accept_o && sys;

    // SRET is unsupported and retires as an illegal-instruction trap.
    assign trap_o = exc || (sys && exwb_i.id_data.sret);
    assign writes = !trap_o && (alu || (bru && bru_i.jump) || sys);

    assign wbrf_o.rd    = writes ? exwb_i.id_data.rd : 5'd0;
    assign wbrf_o.wdata = alu ? alu_i.result : bru ? bru_i.result :
                          sys ? exwb_i.rf_data.csr_rdata : '0;

    assign redirect_o.valid = trap_o || mret || (bru && bru_i.taken);
    assign redirect_o.pc    = trap_o ? exwb_i.rf_data.mtvec :
                              mret ? exwb_i.rf_data.mepc : bru_i.new_pc;

    always_comb begin
        cause_o = exwb_i.if_data.int_exc_code;
        if (!exc) cause_o.exc = EXC_ILLEGAL_INSN;
    end

    assign csr_we_o    = sys && sys_i.csr_update && !trap_o;
    assign csr_wdata_o = sys_i.csr_wdata;

endmodule

// File: rtl/offnariscv_wb.sv
// offnariscv_wb: in-order writeback/commit stage with redirect, trap and CSR-write pulses.
// Optional OFFNARISCV_WB_INSTRET_EN adds a 64-bit retired-instruction counter output.
module offnariscv_wb
    import offnariscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            s_exwb_tvalid,
    output logic            s_exwb_tready,
    input  exwb_tdata_t     s_exwb_tdata,
    input  logic            s_aluwb_tvalid,
    output logic            s_aluwb_tready,
    input  aluwb_tdata_t    s_aluwb_tdata,
    input  logic            s_bruwb_tvalid,
    output logic            s_bruwb_tready,
    input  bruwb_tdata_t    s_bruwb_tdata,
    input  logic            s_syswb_tvalid,
    output logic            s_syswb_tready,
    input  syswb_tdata_t    s_syswb_tdata,
    output logic            m_wbrf_tvalid,
    input  logic            m_wbrf_tready,
    output wbrf_tdata_t     m_wbrf_tdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            trap_valid,
    output int_exc_code_u   trap_cause,
    output logic [XLEN-1:0] trap_epc
`ifdef OFFNARISCV_WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    wb_state_e       state_q, state_d;
    logic            can_accept, accept, trap, csr_we_n;
    wbrf_tdata_t     wbrf_n, wbrf_q;
    redirect_t       redir;
    int_exc_code_u   cause_n, cause_q;
    logic [XLEN-1:0] csr_wdata_n, csr_wdata_q, redirect_pc_q, epc_q;
    logic [11:0]     csr_waddr_q;
    logic            m_valid_q, redirect_valid_q, trap_valid_q, csr_we_q;

    offnariscv_wb_join u_join (
        .can_accept_i (can_accept),
        .exwb_valid_i (s_exwb_tvalid),
        .exwb_i       (s_exwb_tdata),
        .alu_valid_i  (s_aluwb_tvalid),
        .alu_i        (s_aluwb_tdata),
        .bru_valid_i  (s_bruwb_tvalid),
        .bru_i        (s_bruwb_tdata),
        .sys_valid_i  (s_syswb_tvalid),
        .sys_i        (s_syswb_tdata),
        .exwb_ready_o (s_exwb_tready),
        .alu_ready_o  (s_aluwb_tready),
        .bru_ready_o  (s_bruwb_tready),
        .sys_ready_o  (s_syswb_tready),
        .accept_o     (accept),
        .wbrf_o       (wbrf_n),
        .redirect_o   (redir),
        .trap_o       (trap),
        .cause_o      (cause_n),
        .csr_we_o     (csr_we_n),
        .csr_wdata_o  (csr_wdata_n)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= WB_RUN;
        else     state_q <= state_d;
    end

    // KILL lasts exactly one cycle: the window in which upstream sees the redirect pulse.
    always_comb begin
        state_d = (state_q == WB_RUN && accept && redir.valid) ? WB_KILL : WB_RUN;
    end

    always_comb begin
        can_accept = (state_q == WB_RUN) && (!m_valid_q || m_wbrf_tready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            trap_valid_q     <= 1'b0;
            csr_we_q         <= 1'b0;
        end else begin
            m_valid_q        <= accept || (m_valid_q && !m_wbrf_tready);
            redirect_valid_q <= accept && redir.valid;
            trap_valid_q     <= accept && trap;
            csr_we_q         <= accept && csr_we_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wbrf_q        <= wbrf_n;
            redirect_pc_q <= redir.pc;
            cause_q       <= cause_n;
            epc_q         <= s_exwb_tdata.if_data.pc;
            csr_waddr_q   <= s_exwb_tdata.id_data.csr_addr;
            csr_wdata_q   <= csr_wdata_n;
        end
    end

    assign m_wbrf_tvalid  = m_valid_q;
    assign m_wbrf_tdata   = wbrf_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign trap_valid     = trap_valid_q;
    assign trap_cause     = cause_q;
    assign trap_epc       = epc_q;
    assign csr_we         = csr_we_q;
    assign csr_waddr      = csr_waddr_q;
    assign csr_wdata      = csr_wdata_q;

`ifdef OFFNARISCV_WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst)                 instret_q <= '0;
        else if (accept && !trap) instret_q <= instret_q + 64'd1;
    end

    assign instret = instret_q;
`endif

`ifndef SYNTHESIS
    logic [6:0] orphan_q;
    logic       orphan;

    // A unit result waiting with no EX beat that selects it points at a lost or misordered beat.
    assign orphan = (s_aluwb_tvalid && !(s_exwb_tvalid && s_exwb_tdata.id_data.alu_cmd_vld)) ||
                    (s_bruwb_tvalid && !(s_exwb_tvalid && s_exwb_tdata.id_data.bru_cmd_vld)) ||
                    (s_syswb_tvalid && !(s_exwb_tvalid && s_exwb_tdata.id_data.sys_cmd_vld));

    always_ff @(posedge clk) begin
        if (rst || !orphan)         orphan_q <= '0;
        else if (orphan_q != 7'h7f) orphan_q <= orphan_q + 7'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst && s_exwb_tvalid)
            assert ($countones({s_exwb_tdata.id_data.alu_cmd_vld, s_exwb_tdata.id_data.bru_cmd_vld,
                                s_exwb_tdata.id_data.sys_cmd_vld}) <= 1);
        if (!rst) assert (orphan_q <= 7'd64);
    end
`endif

endmodule
